// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master sequencer: START/WRITE/READ/STOP on quarter-period SCL timing, external shift register.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL by freezing the quarter timer in Q1 of DATA/ACK.
module i2c_byte_ctrl #(
  parameter int unsigned QDIV = 4
) (
  input  logic       clk,
  input  logic       rst_an,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_ack,
  output logic [7:0] rx_data,
  output logic       rx_ack,
  output logic       done,
  output logic       busy,
  output logic       sh_clear,
  output logic       sh_shift,
  output logic       sh_load,
  output logic [7:0] sh_parIn,
  output logic       sh_serIn,
  input  logic [3:0] sh_count,
  input  logic       sh_serOut,
  input  logic [7:0] sh_parOut,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] QLAST = CW'(QDIV - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] SETUP = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] ACK   = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  logic [2:0]    state, nState;
  logic [CW-1:0] qcnt, nQcnt;
  logic [1:0]    quarter, nQuarter;
  logic          isRead, nIsRead;
  logic          nSclOe, nSdaOe, nClear, nLoad, nShift, nDone, nSerIn, nRxAck;
  logic [7:0]    nParIn, nRxData;
  logic          adv, lastQ, sampleQ1;

`ifndef I2C_CLK_STRETCH_EN
  logic unusedSclIn;
  assign unusedSclIn = scl_in;
`endif

  // State, quarter timer and direction flag
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state   <= IDLE;
      qcnt    <= '0;
      quarter <= '0;
      isRead  <= 1'b0;
    end else begin
      state   <= nState;
      qcnt    <= nQcnt;
      quarter <= nQuarter;
      isRead  <= nIsRead;
    end
  end

  // Next-state, timer and next-output logic; outputs are registered from the upcoming state/quarter
  always_comb begin
    nState   = state;
    nQcnt    = qcnt;
    nQuarter = quarter;
    nIsRead  = isRead;
    nSclOe   = scl_oe;
    nSdaOe   = sda_oe;
    nClear   = 1'b0;
    nLoad    = 1'b0;
    nShift   = 1'b0;
    nDone    = 1'b0;
    nParIn   = sh_parIn;
    nSerIn   = sh_serIn;
    nRxAck   = rx_ack;
    nRxData  = rx_data;
    adv      = 1'b1;
`ifdef I2C_CLK_STRETCH_EN
    if ((state == DATA || state == ACK) && quarter == 2'd1 && !scl_in) adv = 1'b0;
`endif
    lastQ    = (qcnt == QLAST);
    sampleQ1 = adv && lastQ && (quarter == 2'd1);

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          nQcnt    = '0;
          nQuarter = '0;
          case (cmd)
            CMD_START: nState = START;
            CMD_STOP:  nState = STOP;
            CMD_WRITE: begin
              nState  = SETUP;
              nLoad   = 1'b1;
              nParIn  = tx_data;
              nIsRead = 1'b0;
            end
            default: begin
              nState  = SETUP;
              nClear  = 1'b1;
              nIsRead = 1'b1;
            end
          endcase
        end
      end
      SETUP: nState = DATA;
      default: begin
        if (adv) begin
          if (!lastQ) begin
            nQcnt = qcnt + CW'(1);
          end else begin
            nQcnt    = '0;
            nQuarter = quarter + 2'd1;
            if (quarter == 2'd3) begin
              if (state == DATA) begin
                if (sh_count == 4'd8) nState = ACK;
              end else begin
                nState = IDLE;
                nDone  = 1'b1;
              end
            end
          end
        end
      end
    endcase

    case (nState)
      START: begin
        nSclOe = (nQuarter == 2'd3);
        nSdaOe = nQuarter[1];
      end
      STOP: begin
        nSclOe = (nQuarter == 2'd0);
        nSdaOe = (nQuarter != 2'd3);
      end
      DATA: begin
        nSclOe = (nQuarter == 2'd0) || (nQuarter == 2'd3);
        // Write bit taken one cycle into Q0 so a fresh sh_load has settled
        if (nIsRead) nSdaOe = 1'b0;
        else if (state == DATA && quarter == 2'd0 && qcnt == '0) nSdaOe = ~sh_serOut;
        if (state == DATA && sampleQ1) nSerIn = sda_in;
        nShift = (state == DATA) && (nQuarter == 2'd2) && (nQcnt == QLAST);
      end
      ACK: begin
        nSclOe = (nQuarter == 2'd0) || (nQuarter == 2'd3);
        if (state == DATA) begin
          nSdaOe = isRead ? ~tx_ack : 1'b0;
          if (isRead) nRxData = sh_parOut;
        end
        if (state == ACK && !isRead && sampleQ1) nRxAck = sda_in;
      end
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      sh_clear  <= 1'b0;
      sh_load   <= 1'b0;
      sh_shift  <= 1'b0;
      sh_parIn  <= 8'h00;
      sh_serIn  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      rx_data   <= 8'h00;
      rx_ack    <= 1'b1;
    end else begin
      scl_oe    <= nSclOe;
      sda_oe    <= nSdaOe;
      sh_clear  <= nClear;
      sh_load   <= nLoad;
      sh_shift  <= nShift;
      sh_parIn  <= nParIn;
      sh_serIn  <= nSerIn;
      done      <= nDone;
      busy      <= (nState != IDLE);
      cmd_ready <= (nState == IDLE);
      rx_data   <= nRxData;
      rx_ack    <= nRxAck;
    end
  end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Self-checking bench for i2c_byte_ctrl: scoreboard of expected done events plus directed bus-level checks.
// With I2C_CLK_STRETCH_EN defined an extra clock-stretch scenario is run.
`timescale 1ns/1ps
module tb_i2c_byte_ctrl;

  localparam int unsigned QDIV = 4;
  localparam int LAT_SS = 4 * QDIV + 1;
  localparam int LAT_RW = 36 * QDIV + 2;

  logic       clk = 1'b0;
  logic       rst_an = 1'b0;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd;
  logic [7:0] tx_data, rx_data;
  logic       tx_ack, rx_ack, done, busy;
  logic       sh_clear, sh_shift, sh_load, sh_serIn, sh_serOut;
  logic [7:0] sh_parIn, sh_parOut;
  logic [3:0] sh_count;
  logic       scl_in, sda_in, scl_oe, sda_oe;

  i2c_byte_ctrl #(.QDIV(QDIV)) dut (
    .clk(clk), .rst_an(rst_an),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .tx_data(tx_data), .tx_ack(tx_ack), .rx_data(rx_data), .rx_ack(rx_ack),
    .done(done), .busy(busy),
    .sh_clear(sh_clear), .sh_shift(sh_shift), .sh_load(sh_load),
    .sh_parIn(sh_parIn), .sh_serIn(sh_serIn), .sh_count(sh_count),
    .sh_serOut(sh_serOut), .sh_parOut(sh_parOut),
    .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External shift register model (MSB out, LSB in)
  logic [7:0] shReg = 8'h00;
  logic [3:0] shCnt = 4'd0;
  always @(posedge clk) begin
    if (sh_clear) begin
      shReg <= 8'h00; shCnt <= 4'd0;
    end else if (sh_load) begin
      shReg <= sh_parIn; shCnt <= 4'd0;
    end else if (sh_shift) begin
      shReg <= {shReg[6:0], sh_serIn}; shCnt <= shCnt + 4'd1;
    end
  end
  assign sh_serOut = shReg[7];
  assign sh_parOut = shReg;
  assign sh_count  = shCnt;

  // Slave: mode 1 = ACK a write with ackPull, mode 2 = return rdByte MSB first
  int         slvMode = 0;
  int         slvEpoch = 0;
  logic [7:0] rdByte = 8'h00;
  logic       ackPull = 1'b0;
  logic       sclHold = 1'b0;
  int         fallCnt = 0;
  int         seenEpoch = 0;
  logic       prevScl = 1'b0;
  logic       slaveDrive;
  logic       bitLog[$];
  logic       oeLog[$];

  assign slaveDrive = (slvMode == 2 && fallCnt < 8) ? ~rdByte[3'(7 - fallCnt)] :
                      (slvMode == 1 && fallCnt == 8) ? ackPull : 1'b0;
  assign sda_in = ~(sda_oe | slaveDrive);
  assign scl_in = ~(scl_oe | sclHold);

  always @(negedge clk) begin
    if (slvEpoch != seenEpoch) begin
      seenEpoch = slvEpoch;
      fallCnt = 0;
    end else if (scl_oe && !prevScl) begin
      fallCnt++;
    end
    if (!scl_oe && prevScl) begin
      bitLog.push_back(sda_in);
      oeLog.push_back(sda_oe);
    end
    prevScl = scl_oe;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  typedef struct {
    int         expCyc;
    bit         chkData;
    logic [7:0] expData;
    bit         chkAck;
    logic       expAck;
  } exp_t;
  exp_t expQ[$];

  int doneCnt = 0;
  int shiftCnt = 0;
  int exclViol = 0;

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_an && done) begin
      doneCnt++;
      chk("done_expected", 32'(expQ.size() > 0), 1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("done_cycle", cyc, e.expCyc);
        if (e.chkData) chk("rx_data", rx_data, e.expData);
        if (e.chkAck)  chk("rx_ack", rx_ack, e.expAck);
      end
    end
    if (sh_shift) shiftCnt++;
    if (32'(sh_clear) + 32'(sh_load) + 32'(sh_shift) > 1) exclViol++;
  end

  int sdaRiseAt, sclRelAt, sdaRelAt;
  logic sclAtRise;

  task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic ta, output int acc);
    int g;
    g = 0;
    @(negedge clk);
    while (!cmd_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd = c; tx_data = d; tx_ack = ta; cmd_valid = 1'b1;
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic runOp(input string nm, input int acc, input int maxc);
    bit saw;
    saw = 1'b0;
    sdaRiseAt = -1; sclRelAt = -1; sdaRelAt = -1; sclAtRise = 1'bx;
    for (int k = 0; k < maxc && !saw; k++) begin
      if (sda_oe && sdaRiseAt < 0) begin sdaRiseAt = cyc - acc; sclAtRise = scl_oe; end
      if (!scl_oe && sclRelAt < 0) sclRelAt = cyc - acc;
      if (!sda_oe && sdaRelAt < 0) sdaRelAt = cyc - acc;
      if (done) saw = 1'b1;
      else @(negedge clk);
    end
    chk({nm, "_done_seen"}, 32'(saw), 1);
  endtask

  function automatic logic [7:0] logByte(input int base);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++)
      if (base + i < bitLog.size()) b[7 - i] = bitLog[base + i];
    return b;
  endfunction

  task automatic doStart();
    int acc;
    issue(2'b00, 8'h00, 1'b0, acc);
    expQ.push_back('{acc + LAT_SS, 1'b0, 8'h00, 1'b0, 1'b0});
    runOp("start", acc, 100);
  endtask

  task automatic doWrite(input string nm, input logic [7:0] d, input logic pull, input int extra);
    int acc, base;
    slvMode = 1; ackPull = pull; slvEpoch++;
    base = bitLog.size();
    issue(2'b01, d, 1'b0, acc);
    expQ.push_back('{acc + LAT_RW + extra, 1'b0, 8'h00, 1'b1, ~pull});
    if (extra > 0) begin
      while (cyc < acc + 22) @(negedge clk);
      sclHold = 1'b1;
      while (cyc < acc + 22 + extra) @(negedge clk);
      sclHold = 1'b0;
    end
    runOp(nm, acc, 600);
    chk({nm, "_bits_logged"}, bitLog.size() - base, 9);
    chk({nm, "_sda_seq"}, logByte(base), d);
    slvMode = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, base, sb, db;
    logic busyAny;
    cmd_valid = 1'b0; cmd = 2'b00; tx_data = 8'h00; tx_ack = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_ack", rx_ack, 1);
    chk("rst_strobes", {sh_clear, sh_load, sh_shift}, 3'b000);
    rst_an = 1'b1;
    repeat (2) @(negedge clk);

    // START: SDA pulled while SCL released, then SCL pulled
    issue(2'b00, 8'h00, 1'b0, acc);
    expQ.push_back('{acc + LAT_SS, 1'b0, 8'h00, 1'b0, 1'b0});
    runOp("start", acc, 100);
    chk("start_sda_fall_cycle", sdaRiseAt, 2 * QDIV + 1);
    chk("start_scl_high_at_sda_fall", sclAtRise, 0);
    chk("start_end_scl_oe", scl_oe, 1);

    // STOP: SCL released first, SDA released 2 quarters later
    issue(2'b11, 8'h00, 1'b0, acc);
    expQ.push_back('{acc + LAT_SS, 1'b0, 8'h00, 1'b0, 1'b0});
    runOp("stop", acc, 100);
    chk("stop_scl_release_cycle", sclRelAt, QDIV + 1);
    chk("stop_sda_release_cycle", sdaRelAt, 3 * QDIV + 1);

    // WRITE 0xA5 with slave ACK; a command pulsed mid-transfer must be dropped
    doStart();
    slvMode = 1; ackPull = 1'b1; slvEpoch++;
    base = bitLog.size();
    issue(2'b01, 8'hA5, 1'b0, acc);
    expQ.push_back('{acc + LAT_RW, 1'b0, 8'h00, 1'b1, 1'b0});
    while (cyc < acc + 20) @(negedge clk);
    chk("ready_low_while_busy", cmd_ready, 0);
    cmd = 2'b11; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    runOp("wr_a5", acc, 600);
    chk("wr_a5_sda_seq", logByte(base), 8'hA5);
    slvMode = 0;
    busyAny = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      busyAny = busyAny | busy;
    end
    chk("busy_cmd_not_queued", busyAny, 0);

    // READ 0x3C, master NACKs
    slvMode = 2; rdByte = 8'h3C; slvEpoch++;
    @(negedge clk);
    base = bitLog.size();
    sb = shiftCnt;
    issue(2'b10, 8'h00, 1'b1, acc);
    expQ.push_back('{acc + LAT_RW, 1'b1, 8'h3C, 1'b0, 1'b0});
    runOp("rd_3c", acc, 600);
    chk("rd_shift_pulses", shiftCnt - sb, 8);
    chk("rd_bits_logged", bitLog.size() - base, 9);
    if (oeLog.size() > base + 8) chk("rd_ack_sda_oe", oeLog[base + 8], 0);
    if (bitLog.size() > base + 8) chk("rd_ack_sda_line", bitLog[base + 8], 1);
    slvMode = 0;

    // WRITE 0x3C, slave NACKs
    doWrite("wr_3c_nack", 8'h3C, 1'b0, 0);

    issue(2'b11, 8'h00, 1'b0, acc);
    expQ.push_back('{acc + LAT_SS, 1'b0, 8'h00, 1'b0, 1'b0});
    runOp("stop2", acc, 100);

`ifdef I2C_CLK_STRETCH_EN
    doStart();
    doWrite("wr_stretch", 8'hA5, 1'b1, 20);
`endif

    // Reset in the middle of bit 4 of a write
    doStart();
    slvMode = 1; ackPull = 1'b1; slvEpoch++;
    issue(2'b01, 8'hA5, 1'b0, acc);
    while (cyc < acc + 2 + 3 * 4 * QDIV + 5) @(negedge clk);
    @(posedge clk);
    #2;
    db = doneCnt;
    rst_an = 1'b0;
    #1;
    chk("midrst_scl_oe", scl_oe, 0);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (4) @(negedge clk);
    rst_an = 1'b1;
    slvMode = 0;
    repeat (200) @(negedge clk);
    chk("midrst_no_done", doneCnt - db, 0);
    chk("midrst_idle", busy, 0);

    chk("strobe_exclusive", exclViol, 0);
    chk("queue_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
